// File: rtl/soc_mem_pkg.sv
// Shared constants, state encoding and helpers for the on-chip data memory
// and the arbiters that share it.
package soc_mem_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_DATA = 1'b1
    } arb_state_t;

    // Ceiling log2, never below 1 so a two-entry index still has a bit.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd1;
        while ((32'sd1 <<< result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester scanning upward from the
// slot after last_grant, wrapping modulo NUM_REQ. Reusable by any shared slave.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = soc_mem_pkg::clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               valid,
    output logic [IDX_W-1:0]   grant
);

    // Rotating scan; the first hit wins and later hits only keep valid set.
    always_comb begin
        logic [IDX_W-1:0] cand;
        logic             hit;
        valid = 1'b0;
        grant = '0;
        cand  = '0;
        hit   = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand  = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            hit   = req[cand] & ~valid;
            grant = hit ? cand : grant;
            valid = valid | req[cand];
        end
    end

endmodule

// File: rtl/soc_data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port, one-cycle-latency data memory
// between several Avalon-MM masters; writes finish in one cycle, reads in two.
module soc_data_mem_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = soc_mem_pkg::ADDR_W,
    parameter int DATA_W      = soc_mem_pkg::DATA_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_byteenable,
    input  logic [NUM_MASTERS-1:0]          m_read,
    input  logic [NUM_MASTERS-1:0]          m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
    output logic [DATA_W-1:0]               m_readdata,
    output logic [NUM_MASTERS-1:0]          m_waitrequest,
    output logic [ADDR_W-1:0]               mem_address,
    output logic [(DATA_W/8)-1:0]           mem_byteenable,
    output logic                            mem_chipselect,
    output logic                            mem_write,
    output logic [DATA_W-1:0]               mem_writedata,
    output logic                            mem_clken,
    input  logic [DATA_W-1:0]               mem_readdata
);

    import soc_mem_pkg::*;

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = soc_mem_pkg::clog2(NUM_MASTERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    arb_state_t         state;
    arb_state_t         next_state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   next_last_grant;
    logic [IDX_W-1:0]   rd_master;
    logic [IDX_W-1:0]   next_rd_master;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ADDR_W-1:0]  next_rd_addr;

    logic [NUM_MASTERS-1:0] req_s;
    logic                   pick_valid_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic                   win_write_s;
    logic [ADDR_W-1:0]      win_addr_s;
    logic [BE_W-1:0]        win_be_s;
    logic [DATA_W-1:0]      win_data_s;

    // A master holding both read and write is served as a writer.
    assign req_s       = m_read | m_write;
    assign win_write_s = m_write[pick_idx_s];
    assign win_addr_s  = m_address[pick_idx_s*ADDR_W +: ADDR_W];
    assign win_be_s    = m_byteenable[pick_idx_s*BE_W +: BE_W];
    assign win_data_s  = m_writedata[pick_idx_s*DATA_W +: DATA_W];
    assign mem_clken   = 1'b1;

    rr_priority_picker #(
        .NUM_REQ (NUM_MASTERS),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req_s),
        .last_grant (last_grant),
        .valid      (pick_valid_s),
        .grant      (pick_idx_s)
    );

    // State and arbitration history; reset leaves master 0 with first priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= LAST_IDX;
            rd_master  <= '0;
            rd_addr    <= '0;
        end else begin
            state      <= next_state;
            last_grant <= next_last_grant;
            rd_master  <= next_rd_master;
            rd_addr    <= next_rd_addr;
        end
    end

    // Next-state and all memory/master-side outputs; reset forces the idle bus.
    always_comb begin
        next_state      = state;
        next_last_grant = last_grant;
        next_rd_master  = rd_master;
        next_rd_addr    = rd_addr;
        mem_address     = '0;
        mem_byteenable  = '0;
        mem_chipselect  = 1'b0;
        mem_write       = 1'b0;
        mem_writedata   = '0;
        m_waitrequest   = '1;
        m_readdata      = '0;
        if (reset) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        mem_chipselect = 1'b1;
                        mem_address    = win_addr_s;
                        if (win_write_s) begin
                            mem_write                 = 1'b1;
                            mem_byteenable            = win_be_s;
                            mem_writedata             = win_data_s;
                            m_waitrequest[pick_idx_s] = 1'b0;
                            next_last_grant           = pick_idx_s;
                        end else begin
                            next_rd_master = pick_idx_s;
                            next_rd_addr   = win_addr_s;
                            next_state     = ST_RD_DATA;
                        end
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
                ST_RD_DATA: begin
                    // Address held so the memory keeps presenting the same word.
                    mem_chipselect           = 1'b1;
                    mem_address              = rd_addr;
                    m_readdata               = mem_readdata;
                    m_waitrequest[rd_master] = 1'b0;
                    next_last_grant          = rd_master;
                    next_state               = ST_IDLE;
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_data_mem_arbiter.sv
// Self-checking bench: directed scenarios plus random Avalon masters, compared
// cycle by cycle against a transaction-level round-robin model.
module tb_soc_data_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int BW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N*AW-1:0]   m_address;
    logic [N*BW-1:0]   m_byteenable;
    logic [N-1:0]      m_read;
    logic [N-1:0]      m_write;
    logic [N*DW-1:0]   m_writedata;
    logic [DW-1:0]     m_readdata;
    logic [N-1:0]      m_waitrequest;
    logic [AW-1:0]     mem_address;
    logic [BW-1:0]     mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DW-1:0]     mem_writedata;
    logic              mem_clken;
    logic [DW-1:0]     mem_readdata;

    always #5 clk = ~clk;

    soc_data_mem_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .m_address      (m_address),
        .m_byteenable   (m_byteenable),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_writedata    (m_writedata),
        .m_readdata     (m_readdata),
        .m_waitrequest  (m_waitrequest),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    // Memory: registered address, unregistered output, byte-enabled writes.
    logic [DW-1:0] mem_array [512];
    logic [AW-1:0] mem_addr_q;
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) begin
            mem_array[pl_addr] <= pl_data;
        end else if (mem_clken && mem_chipselect) begin
            mem_addr_q <= mem_address;
            if (mem_write) begin
                for (int b = 0; b < BW; b++) begin
                    if (mem_byteenable[b]) mem_array[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
        end
    end
    assign mem_readdata = mem_array[mem_addr_q];

    // Master-side intent and reference model state.
    logic          rq_rd   [N];
    logic          rq_wr   [N];
    logic [AW-1:0] rq_addr [N];
    logic [BW-1:0] rq_be   [N];
    logic [DW-1:0] rq_data [N];
    logic [DW-1:0] ref_mem [512];
    int            last_idx;
    int            pend;
    logic [AW-1:0] pend_addr;
    int            done_log [$];
    logic [DW-1:0] obs_rdata;
    logic          obs_mem_write;
    int            errors = 0;
    int            checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 32'h155) return 32'hDEAD_BEEF;
        return DW'(a * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    task automatic drive_masters();
        for (int i = 0; i < N; i++) begin
            m_read[i]                 = rq_rd[i];
            m_write[i]                = rq_wr[i];
            m_address[i*AW +: AW]     = rq_addr[i];
            m_byteenable[i*BW +: BW]  = rq_be[i];
            m_writedata[i*DW +: DW]   = rq_data[i];
        end
    endtask

    task automatic clear_masters();
        for (int i = 0; i < N; i++) begin
            rq_rd[i] = 1'b0; rq_wr[i] = 1'b0; rq_addr[i] = '0; rq_be[i] = '0; rq_data[i] = '0;
        end
        drive_masters();
    endtask

    // One clock: predict from the model, compare at negedge, advance, retire.
    task automatic step();
        logic [N-1:0]  exp_wait;
        logic          exp_cs;
        logic          exp_wr;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] word;
        int            win;
        int            done;
        int            idx;
        exp_wait = '1; exp_cs = 1'b0; exp_wr = 1'b0; exp_addr = '0; win = -1; done = -1;
        @(negedge clk);
        if (pend >= 0) begin
            exp_cs = 1'b1;
            exp_addr = pend_addr;
            exp_wait[pend] = 1'b0;
            check_eq("read_data", m_readdata, ref_mem[pend_addr]);
            obs_rdata = m_readdata;
        end else begin
            for (int k = 1; k <= N; k++) begin
                idx = (last_idx + k) % N;
                if (win < 0 && (rq_rd[idx] || rq_wr[idx])) win = idx;
            end
            if (win >= 0) begin
                exp_cs = 1'b1;
                exp_addr = rq_addr[win];
                exp_wr = rq_wr[win];
                if (exp_wr) exp_wait[win] = 1'b0;
            end
        end
        obs_mem_write = mem_write;
        check_eq("waitrequest", m_waitrequest, exp_wait);
        check_eq("chipselect", mem_chipselect, exp_cs);
        check_eq("mem_write", mem_write, exp_wr);
        check_eq("clken", mem_clken, 1'b1);
        if (exp_cs) check_eq("mem_address", mem_address, exp_addr);
        if (exp_wr) begin
            check_eq("mem_byteenable", mem_byteenable, rq_be[win]);
            check_eq("mem_writedata", mem_writedata, rq_data[win]);
        end
        if (pend >= 0) begin
            done = pend; last_idx = pend; pend = -1;
        end else if (win >= 0) begin
            if (exp_wr) begin
                word = ref_mem[rq_addr[win]];
                for (int b = 0; b < BW; b++) begin
                    if (rq_be[win][b]) word[8*b +: 8] = rq_data[win][8*b +: 8];
                end
                ref_mem[rq_addr[win]] = word;
                done = win; last_idx = win;
            end else begin
                pend = win; pend_addr = rq_addr[win];
            end
        end
        @(posedge clk); #1;
        if (done >= 0) begin
            rq_rd[done] = 1'b0; rq_wr[done] = 1'b0;
            done_log.push_back(done);
        end
        drive_masters();
    endtask

    initial begin
        int start;
        int kind;
        reset = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        pend = -1; last_idx = N - 1; obs_rdata = '0; obs_mem_write = 1'b0;
        clear_masters();
        // A request during reset must not reach the memory side.
        rq_wr[1] = 1'b1; rq_addr[1] = 9'h0AB; rq_be[1] = 4'hF; rq_data[1] = 32'h1111_2222;
        drive_masters();
        for (int a = 0; a < 512; a++) begin
            pl_en = 1'b1; pl_addr = AW'(a); pl_data = init_word(a); ref_mem[a] = init_word(a);
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
        @(negedge clk);
        check_eq("rst_waitrequest", m_waitrequest, 4'b1111);
        check_eq("rst_chipselect", mem_chipselect, 1'b0);
        check_eq("rst_mem_write", mem_write, 1'b0);
        check_eq("rst_address", mem_address, 9'h000);
        check_eq("rst_writedata", mem_writedata, 32'h0);
        check_eq("rst_readdata", m_readdata, 32'h0);
        check_eq("rst_clken", mem_clken, 1'b1);
        clear_masters();
        reset = 1'b0;
        @(posedge clk); #1;

        // Single read by master 2.
        rq_rd[2] = 1'b1; rq_addr[2] = 9'h155; rq_be[2] = 4'hF;
        drive_masters();
        step(); step();
        check_eq("single_read_data", obs_rdata, 32'hDEAD_BEEF);
        check_eq("single_read_who", done_log[$], 2);

        // Single half-word write by master 1, then read it back.
        rq_wr[1] = 1'b1; rq_addr[1] = 9'h010; rq_be[1] = 4'b0011; rq_data[1] = 32'h1234_5678;
        drive_masters();
        step();
        check_eq("single_write_flag", obs_mem_write, 1'b1);
        rq_rd[1] = 1'b1; rq_addr[1] = 9'h010; rq_be[1] = 4'hF;
        drive_masters();
        step(); step();
        check_eq("write_readback_low", obs_rdata[15:0], 16'h5678);
        check_eq("write_readback", obs_rdata, (init_word(32'h010) & 32'hFFFF_0000) | 32'h0000_5678);

        // Full write contention: one grant per cycle, strict rotation.
        start = done_log.size();
        repeat (12) begin
            for (int i = 0; i < N; i++) begin
                rq_wr[i] = 1'b1; rq_addr[i] = AW'($urandom_range(32, 63));
                rq_be[i] = 4'hF; rq_data[i] = $urandom;
            end
            drive_masters();
            step();
        end
        clear_masters();
        check_eq("contention_count", done_log.size() - start, 12);
        check_eq("contention_first", done_log[start], 2);
        for (int k = 1; k < 12; k++) begin
            check_eq("contention_order", done_log[start+k], (done_log[start+k-1] + 1) % N);
        end

        // Read and write together are served as a write.
        rq_rd[0] = 1'b1; rq_wr[0] = 1'b1; rq_addr[0] = 9'h020; rq_be[0] = 4'hF; rq_data[0] = 32'hCAFE_F00D;
        drive_masters();
        step();
        check_eq("rdwr_as_write", obs_mem_write, 1'b1);

        // Reset in the middle of a read drops it at once.
        rq_rd[2] = 1'b1; rq_addr[2] = 9'h155; rq_be[2] = 4'hF;
        drive_masters();
        step();
        #2 reset = 1'b1;
        #1;
        check_eq("midrd_waitrequest", m_waitrequest, 4'b1111);
        check_eq("midrd_chipselect", mem_chipselect, 1'b0);
        check_eq("midrd_address", mem_address, 9'h000);
        check_eq("midrd_readdata", m_readdata, 32'h0);
        clear_masters();
        pend = -1; last_idx = N - 1;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // Mixed contention right after reset: 0 read, 1 write, 3 read.
        rq_rd[0] = 1'b1; rq_addr[0] = 9'h155; rq_be[0] = 4'hF;
        rq_wr[1] = 1'b1; rq_addr[1] = 9'h030; rq_be[1] = 4'hF; rq_data[1] = 32'h0BAD_F00D;
        rq_rd[3] = 1'b1; rq_addr[3] = 9'h010; rq_be[3] = 4'hF;
        drive_masters();
        start = done_log.size();
        repeat (5) step();
        check_eq("mixed_count", done_log.size() - start, 3);
        check_eq("mixed_first", done_log[start], 0);
        check_eq("mixed_second", done_log[start+1], 1);
        check_eq("mixed_third", done_log[start+2], 3);

        // Random Avalon masters holding requests until served.
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!rq_rd[i] && !rq_wr[i] && $urandom_range(0, 2) == 0) begin
                    kind = $urandom_range(0, 3);
                    rq_rd[i]   = (kind == 0) || (kind == 3);
                    rq_wr[i]   = (kind != 0);
                    rq_addr[i] = AW'($urandom_range(0, 15)) | ($urandom_range(0, 1) ? 9'h1F0 : 9'h000);
                    rq_be[i]   = BW'($urandom_range(1, 15));
                    rq_data[i] = $urandom;
                end
            end
            drive_masters();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
